// File: rtl/intra4_pred_engine.sv
// 4x4 intra luma predictor (DC, TM, VE, HE, HU, LD) with VP8 rounding.
// Accepts one block's edge samples and a mode, computes all 16 samples in one
// cycle, then streams the prediction out one row per valid/ready beat.
module intra4_pred_engine #(
  parameter int BIT_WIDTH  = 8,
  parameter int BLOCK_SIZE = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [2:0]             in_mode,
  input  logic [BIT_WIDTH*4-1:0] in_top,
  input  logic [BIT_WIDTH*4-1:0] in_top_right,
  input  logic [BIT_WIDTH*4-1:0] in_left,
  input  logic [BIT_WIDTH-1:0]   in_top_left,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [BIT_WIDTH*4-1:0] out_row,
  output logic [1:0]             out_row_idx,
  output logic                   out_last,
  output logic                   out_err,
  output logic                   busy
);

  localparam int BW = BIT_WIDTH;

  generate
    if (BLOCK_SIZE != 4) begin : g_bad_block_size
      $error("intra4_pred_engine: BLOCK_SIZE must be 4");
    end
  endgenerate

  typedef enum logic [1:0] {IDLE, CALC, EMIT} state_t;
  state_t state;

  // Stage p0: edges and mode captured at accept
  logic [2:0]    mode_p0;
  logic [BW-1:0] top_p0 [8];
  logic [BW-1:0] left_p0 [4];
  logic [BW-1:0] corner_p0;

  // Stage p1: full prediction block, one packed row per entry
  logic [4*BW-1:0] rows_p1 [4];

  logic [BW-1:0]   pred_c [16];
  logic [4*BW-1:0] rows_c [4];
  logic [BW-1:0]   te [9];
  logic [BW-1:0]   le [6];
  logic [BW-1:0]   tx [9];
  logic [BW+2:0]   dc_sum;
  logic [BW-1:0]   dc_val;
  logic [BW-1:0]   hu_v [7];

  function automatic logic [BW-1:0] avg2(input logic [BW-1:0] a, input logic [BW-1:0] b);
    logic [BW+2:0] s;
    s = {3'b000, a} + {3'b000, b} + (BW+3)'(1);
    return s[BW:1];
  endfunction

  function automatic logic [BW-1:0] avg3(input logic [BW-1:0] a, input logic [BW-1:0] b,
                                         input logic [BW-1:0] c);
    logic [BW+2:0] s;
    s = {3'b000, a} + {2'b00, b, 1'b0} + {3'b000, c} + (BW+3)'(2);
    return s[BW+1:2];
  endfunction

  // L + T - P spans [-(2^BW-1), 2*(2^BW-1)], so BW+2 signed bits hold it exactly
  function automatic logic [BW-1:0] tm_clip(input logic [BW-1:0] l, input logic [BW-1:0] t,
                                            input logic [BW-1:0] p);
    logic signed [BW+1:0] s;
    s = $signed({2'b00, l}) + $signed({2'b00, t}) - $signed({2'b00, p});
    if (s[BW+1])
      return '0;
    else if (s[BW])
      return '1;
    else
      return s[BW-1:0];
  endfunction

  // Compute all 16 prediction samples from the latched edges
  always_comb begin
    for (int i = 0; i < 16; i++) pred_c[i] = '0;
    // te: T[-1..7] shifted by one; le: L[-1..4] shifted by one with L[4]=L[3]
    te[0] = corner_p0;
    for (int i = 0; i < 8; i++) te[i+1] = top_p0[i];
    le[0] = corner_p0;
    for (int i = 0; i < 4; i++) le[i+1] = left_p0[i];
    le[5] = left_p0[3];
    // Extending T[8]=T[7] makes the LD corner avg3(T6,T7,T7) fall out of the general formula
    for (int i = 0; i < 8; i++) tx[i] = top_p0[i];
    tx[8] = top_p0[7];
    dc_sum = (BW+3)'(4);
    for (int i = 0; i < 4; i++) dc_sum = dc_sum + {3'b000, top_p0[i]} + {3'b000, left_p0[i]};
    dc_val = dc_sum[BW+2:3];
    hu_v[0] = avg2(left_p0[0], left_p0[1]);
    hu_v[1] = avg2(left_p0[1], left_p0[2]);
    hu_v[2] = avg2(left_p0[2], left_p0[3]);
    hu_v[3] = avg3(left_p0[0], left_p0[1], left_p0[2]);
    hu_v[4] = avg3(left_p0[1], left_p0[2], left_p0[3]);
    hu_v[5] = avg3(left_p0[2], left_p0[3], left_p0[3]);
    hu_v[6] = left_p0[3];
    case (mode_p0)
      3'd0: for (int i = 0; i < 16; i++) pred_c[i] = dc_val;
      3'd1: for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                pred_c[r*4+c] = tm_clip(left_p0[r], top_p0[c], corner_p0);
      3'd2: for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                pred_c[r*4+c] = avg3(te[c], te[c+1], te[c+2]);
      3'd3: for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                pred_c[r*4+c] = avg3(le[r], le[r+1], le[r+2]);
      3'd4: begin
        pred_c[0]  = hu_v[0]; pred_c[1]  = hu_v[3]; pred_c[2]  = hu_v[1]; pred_c[3]  = hu_v[4];
        pred_c[4]  = hu_v[1]; pred_c[5]  = hu_v[4]; pred_c[6]  = hu_v[2]; pred_c[7]  = hu_v[5];
        pred_c[8]  = hu_v[2]; pred_c[9]  = hu_v[5]; pred_c[10] = hu_v[6]; pred_c[11] = hu_v[6];
        pred_c[12] = hu_v[6]; pred_c[13] = hu_v[6]; pred_c[14] = hu_v[6]; pred_c[15] = hu_v[6];
      end
      3'd5: for (int r = 0; r < 4; r++)
              for (int c = 0; c < 4; c++)
                pred_c[r*4+c] = avg3(tx[r+c], tx[r+c+1], tx[r+c+2]);
      default: for (int i = 0; i < 16; i++) pred_c[i] = '0;
    endcase
    for (int r = 0; r < 4; r++)
      rows_c[r] = {pred_c[r*4+3], pred_c[r*4+2], pred_c[r*4+1], pred_c[r*4]};
  end

  // Data path registers: edges on accept, prediction block at the end of CALC
  always_ff @(posedge clk) begin
    if (state == IDLE && in_valid) begin
      mode_p0   <= in_mode;
      corner_p0 <= in_top_left;
      for (int i = 0; i < 4; i++) begin
        top_p0[i]   <= in_top[BW*i +: BW];
        top_p0[4+i] <= in_top_right[BW*i +: BW];
        left_p0[i]  <= in_left[BW*i +: BW];
      end
    end
    if (state == CALC)
      for (int r = 0; r < 4; r++) rows_p1[r] <= rows_c[r];
  end

  // Control FSM with registered handshake and output signals
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      in_ready    <= 1'b1;
      busy        <= 1'b0;
      out_valid   <= 1'b0;
      out_row     <= '0;
      out_row_idx <= 2'd0;
      out_last    <= 1'b0;
      out_err     <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            state    <= CALC;
            in_ready <= 1'b0;
            busy     <= 1'b1;
          end
        end
        CALC: begin
          state       <= EMIT;
          out_valid   <= 1'b1;
          out_row     <= rows_c[0];
          out_row_idx <= 2'd0;
          out_last    <= 1'b0;
          out_err     <= (mode_p0 > 3'd5);
        end
        EMIT: begin
          if (out_ready) begin
            if (out_row_idx == 2'd3) begin
              state       <= IDLE;
              in_ready    <= 1'b1;
              busy        <= 1'b0;
              out_valid   <= 1'b0;
              out_row     <= '0;
              out_row_idx <= 2'd0;
              out_last    <= 1'b0;
              out_err     <= 1'b0;
            end else begin
              out_row     <= rows_p1[out_row_idx + 2'd1];
              out_row_idx <= out_row_idx + 2'd1;
              out_last    <= (out_row_idx == 2'd2);
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_intra4_pred_engine.sv
// Directed bench for intra4_pred_engine: every mode, TM clipping, LD corner,
// illegal mode, backpressure hold and mid-block reset.
module tb_intra4_pred_engine;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [2:0]  in_mode;
  logic [31:0] in_top;
  logic [31:0] in_top_right;
  logic [31:0] in_left;
  logic [7:0]  in_top_left;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_row;
  logic [1:0]  out_row_idx;
  logic        out_last;
  logic        out_err;
  logic        busy;

  int n_checks = 0;
  int n_fail   = 0;

  intra4_pred_engine #(.BIT_WIDTH(8), .BLOCK_SIZE(4)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_mode(in_mode),
    .in_top(in_top), .in_top_right(in_top_right), .in_left(in_left),
    .in_top_left(in_top_left),
    .out_valid(out_valid), .out_ready(out_ready), .out_row(out_row),
    .out_row_idx(out_row_idx), .out_last(out_last), .out_err(out_err),
    .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pk(input int a, input int b, input int c, input int d);
    logic [7:0] a8, b8, c8, d8;
    a8 = a[7:0]; b8 = b[7:0]; c8 = c[7:0]; d8 = d[7:0];
    return {d8, c8, b8, a8};
  endfunction

  function automatic logic [127:0] rows4(input logic [31:0] r0, input logic [31:0] r1,
                                         input logic [31:0] r2, input logic [31:0] r3);
    return {r3, r2, r1, r0};
  endfunction

  task automatic present(input logic [2:0] mode, input logic [31:0] top, input logic [31:0] tr,
                         input logic [31:0] left, input logic [7:0] p);
    in_mode = mode; in_top = top; in_top_right = tr; in_left = left; in_top_left = p;
    in_valid = 1'b1;
  endtask

  // One full block with out_ready held high; checks latency, every row and the return to IDLE
  task automatic run_block(input string tag, input logic [2:0] mode, input logic [31:0] top,
                           input logic [31:0] tr, input logic [31:0] left, input logic [7:0] p,
                           input logic [127:0] exp, input logic exp_err);
    out_ready = 1'b1;
    present(mode, top, tr, left, p);
    check({tag, ".in_ready_idle"}, in_ready, 1'b1);
    step();
    in_valid = 1'b0;
    in_top = '1; in_top_right = '1; in_left = '1; in_top_left = '1; in_mode = 3'd0;
    check({tag, ".calc_valid"}, out_valid, 1'b0);
    check({tag, ".calc_busy"}, busy, 1'b1);
    step();
    for (int r = 0; r < 4; r++) begin
      check($sformatf("%s.valid%0d", tag, r), out_valid, 1'b1);
      check($sformatf("%s.row%0d", tag, r), out_row, exp[32*r +: 32]);
      check($sformatf("%s.idx%0d", tag, r), out_row_idx, r[1:0]);
      check($sformatf("%s.last%0d", tag, r), out_last, (r == 3));
      check($sformatf("%s.err%0d", tag, r), out_err, exp_err);
      check($sformatf("%s.in_ready%0d", tag, r), in_ready, 1'b0);
      step();
    end
    check({tag, ".done_valid"}, out_valid, 1'b0);
    check({tag, ".done_in_ready"}, in_ready, 1'b1);
    check({tag, ".done_busy"}, busy, 1'b0);
  endtask

  logic [127:0] hu_exp;

  initial begin
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    in_mode = '0; in_top = '0; in_top_right = '0; in_left = '0; in_top_left = '0;
    step(); step();
    check("rst.in_ready", in_ready, 1'b1);
    check("rst.out_valid", out_valid, 1'b0);
    check("rst.out_row", out_row, 32'd0);
    check("rst.idx", out_row_idx, 2'd0);
    check("rst.last", out_last, 1'b0);
    check("rst.err", out_err, 1'b0);
    check("rst.busy", busy, 1'b0);
    rst = 1'b0;
    step();

    hu_exp = rows4(pk(15, 20, 25, 30), pk(25, 30, 35, 38), pk(35, 38, 40, 40), pk(40, 40, 40, 40));
    run_block("hu", 3'd4, pk(1, 2, 3, 4), pk(5, 6, 7, 8), pk(10, 20, 30, 40), 8'd99, hu_exp, 1'b0);

    run_block("dc", 3'd0, pk(255, 255, 255, 255), pk(9, 9, 9, 9), pk(0, 0, 0, 0), 8'd7,
              rows4(pk(128, 128, 128, 128), pk(128, 128, 128, 128),
                    pk(128, 128, 128, 128), pk(128, 128, 128, 128)), 1'b0);

    run_block("tm_hi", 3'd1, pk(250, 250, 250, 250), pk(0, 0, 0, 0), pk(10, 10, 10, 10), 8'd0,
              rows4(pk(255, 255, 255, 255), pk(255, 255, 255, 255),
                    pk(255, 255, 255, 255), pk(255, 255, 255, 255)), 1'b0);

    run_block("tm_lo", 3'd1, pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 0), 8'd200,
              128'd0, 1'b0);

    run_block("tm_mid", 3'd1, pk(1, 2, 3, 4), pk(0, 0, 0, 0), pk(10, 20, 30, 40), 8'd5,
              rows4(pk(6, 7, 8, 9), pk(16, 17, 18, 19), pk(26, 27, 28, 29), pk(36, 37, 38, 39)), 1'b0);

    run_block("ld", 3'd5, pk(0, 0, 0, 0), pk(0, 0, 0, 255), pk(50, 60, 70, 80), 8'd33,
              rows4(pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(0, 0, 0, 64), pk(0, 0, 64, 191)), 1'b0);

    run_block("ve", 3'd2, pk(4, 8, 12, 16), pk(100, 0, 0, 0), pk(1, 1, 1, 1), 8'd100,
              rows4(pk(29, 8, 12, 36), pk(29, 8, 12, 36), pk(29, 8, 12, 36), pk(29, 8, 12, 36)), 1'b0);

    run_block("he", 3'd3, pk(1, 1, 1, 1), pk(1, 1, 1, 1), pk(4, 8, 12, 16), 8'd100,
              rows4(pk(29, 29, 29, 29), pk(8, 8, 8, 8), pk(12, 12, 12, 12), pk(15, 15, 15, 15)), 1'b0);

    run_block("illegal", 3'd7, pk(9, 8, 7, 6), pk(5, 4, 3, 2), pk(11, 22, 33, 44), 8'd55,
              128'd0, 1'b1);

    // Backpressure: stall three cycles on row 1
    out_ready = 1'b1;
    present(3'd4, pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(10, 20, 30, 40), 8'd0);
    step();
    in_valid = 1'b0;
    step();
    check("bp.row0", out_row, hu_exp[31:0]);
    step();
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("bp.stall_valid%0d", k), out_valid, 1'b1);
      check($sformatf("bp.stall_row%0d", k), out_row, hu_exp[63:32]);
      check($sformatf("bp.stall_idx%0d", k), out_row_idx, 2'd1);
      step();
    end
    out_ready = 1'b1;
    check("bp.row1_release", out_row, hu_exp[63:32]);
    step();
    check("bp.row2", out_row, hu_exp[95:64]);
    check("bp.idx2", out_row_idx, 2'd2);
    step();
    check("bp.row3", out_row, hu_exp[127:96]);
    check("bp.last3", out_last, 1'b1);
    check("bp.in_ready_before", in_ready, 1'b0);
    step();
    check("bp.in_ready_after", in_ready, 1'b1);
    check("bp.valid_after", out_valid, 1'b0);

    // Reset while row 2 is on the output
    out_ready = 1'b1;
    present(3'd4, pk(0, 0, 0, 0), pk(0, 0, 0, 0), pk(10, 20, 30, 40), 8'd0);
    step();
    in_valid = 1'b0;
    step(); step(); step();
    check("mid_rst.pre_idx", out_row_idx, 2'd2);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst.valid", out_valid, 1'b0);
    check("mid_rst.busy", busy, 1'b0);
    check("mid_rst.in_ready", in_ready, 1'b1);
    check("mid_rst.row", out_row, 32'd0);
    step();
    check("mid_rst.stay_idle", out_valid, 1'b0);

    run_block("post_rst", 3'd0, pk(8, 8, 8, 8), pk(0, 0, 0, 0), pk(16, 16, 16, 16), 8'd0,
              rows4(pk(12, 12, 12, 12), pk(12, 12, 12, 12), pk(12, 12, 12, 12), pk(12, 12, 12, 12)), 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
